// File: rtl/issue_select_scoreboard.sv
// Issue select with register scoreboard: picks up to two hazard-free entries
// from the four oldest queue entries. Optional macro ISSUE_WB_BYPASS_EN.
module issue_select_scoreboard #(
    parameter int REG_AW = 5,
    parameter int OP_W   = 4,
    parameter int IME_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_en,
    input  logic                   ex_stall,
    input  logic                   out_1_vld,
    input  logic [REG_AW-1:0]      out_1_des,
    input  logic [REG_AW-1:0]      out_1_s1,
    input  logic [REG_AW-1:0]      out_1_s2,
    input  logic [OP_W-1:0]        out_1_op,
    input  logic [IME_W-1:0]       out_1_ime,
    input  logic                   out_1_branch,
    input  logic                   out_2_vld,
    input  logic [REG_AW-1:0]      out_2_des,
    input  logic [REG_AW-1:0]      out_2_s1,
    input  logic [REG_AW-1:0]      out_2_s2,
    input  logic [OP_W-1:0]        out_2_op,
    input  logic [IME_W-1:0]       out_2_ime,
    input  logic                   out_2_branch,
    input  logic                   out_3_vld,
    input  logic [REG_AW-1:0]      out_3_des,
    input  logic [REG_AW-1:0]      out_3_s1,
    input  logic [REG_AW-1:0]      out_3_s2,
    input  logic [OP_W-1:0]        out_3_op,
    input  logic [IME_W-1:0]       out_3_ime,
    input  logic                   out_3_branch,
    input  logic                   out_4_vld,
    input  logic [REG_AW-1:0]      out_4_des,
    input  logic [REG_AW-1:0]      out_4_s1,
    input  logic [REG_AW-1:0]      out_4_s2,
    input  logic [OP_W-1:0]        out_4_op,
    input  logic [IME_W-1:0]       out_4_ime,
    input  logic                   out_4_branch,
    input  logic                   wb_1_vld,
    input  logic [REG_AW-1:0]      wb_1_des,
    input  logic                   wb_2_vld,
    input  logic [REG_AW-1:0]      wb_2_des,
    output logic                   ins_in_1,
    output logic                   ins_in_2,
    output logic                   ins_in_3,
    output logic                   ins_in_4,
    output logic                   iss_a_vld,
    output logic [REG_AW-1:0]      iss_a_des,
    output logic [REG_AW-1:0]      iss_a_s1,
    output logic [REG_AW-1:0]      iss_a_s2,
    output logic [OP_W-1:0]        iss_a_op,
    output logic [IME_W-1:0]       iss_a_ime,
    output logic                   iss_a_branch,
    output logic                   iss_b_vld,
    output logic [REG_AW-1:0]      iss_b_des,
    output logic [REG_AW-1:0]      iss_b_s1,
    output logic [REG_AW-1:0]      iss_b_s2,
    output logic [OP_W-1:0]        iss_b_op,
    output logic [IME_W-1:0]       iss_b_ime,
    output logic                   iss_b_branch,
    output logic [2**REG_AW-1:0]   sb_busy
);

    localparam int NREG = 2**REG_AW;

    logic [3:0]        e_vld;
    logic [3:0]        e_br;
    logic [3:0]        s2_used;
    logic [REG_AW-1:0] e_des [4];
    logic [REG_AW-1:0] e_s1  [4];
    logic [REG_AW-1:0] e_s2  [4];
    logic [OP_W-1:0]   e_op  [4];
    logic [IME_W-1:0]  e_ime [4];

    logic [NREG-1:0]   wb_clr;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   busy_eff;
    logic [3:0]        sel;
    logic              sel_allow;
    logic              a_hit, b_hit;
    logic [1:0]        a_idx, b_idx;

    assign e_vld = {out_4_vld, out_3_vld, out_2_vld, out_1_vld};
    assign e_br  = {out_4_branch, out_3_branch, out_2_branch, out_1_branch};

    assign e_des[0] = out_1_des;  assign e_s1[0] = out_1_s1;  assign e_s2[0] = out_1_s2;
    assign e_des[1] = out_2_des;  assign e_s1[1] = out_2_s1;  assign e_s2[1] = out_2_s2;
    assign e_des[2] = out_3_des;  assign e_s1[2] = out_3_s1;  assign e_s2[2] = out_3_s2;
    assign e_des[3] = out_4_des;  assign e_s1[3] = out_4_s1;  assign e_s2[3] = out_4_s2;
    assign e_op[0]  = out_1_op;   assign e_ime[0] = out_1_ime;
    assign e_op[1]  = out_2_op;   assign e_ime[1] = out_2_ime;
    assign e_op[2]  = out_3_op;   assign e_ime[2] = out_3_ime;
    assign e_op[3]  = out_4_op;   assign e_ime[3] = out_4_ime;

    // A non-zero immediate replaces the second source operand.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s2_used[k] = (e_ime[k] == '0);
        end
    end

    always_comb begin
        wb_clr = '0;
        if (wb_1_vld) wb_clr[wb_1_des] = 1'b1;
        if (wb_2_vld) wb_clr[wb_2_des] = 1'b1;
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign busy_eff = sb_busy & ~wb_clr;
`else
    assign busy_eff = sb_busy;
`endif

    assign sel_allow = !rst && !flush_en && !ex_stall;

    // NOTE: combinational scratch variables use blocking assignments so that
    // later iterations see earlier selections; each gets a default first.
    always_comb begin
        logic [3:0] s;
        logic       ok;
        s     = '0;
        ok    = 1'b0;
        a_hit = 1'b0;
        b_hit = 1'b0;
        a_idx = 2'd0;
        b_idx = 2'd0;
        if (sel_allow) begin
            for (int k = 0; k < 4; k++) begin
                ok = e_vld[k] && !busy_eff[e_s1[k]] && !busy_eff[e_des[k]]
                     && (!s2_used[k] || !busy_eff[e_s2[k]])
                     && (k == 0 || !e_br[k]);
                for (int j = 0; j < 4; j++) begin
                    if (j < k && e_vld[j]) begin
                        if (e_des[j] != '0 && (e_des[j] == e_s1[k]
                            || (s2_used[k] && e_des[j] == e_s2[k])))
                            ok = 1'b0;
                        if (e_des[k] != '0 && e_des[j] == e_des[k])
                            ok = 1'b0;
                        // An older entry left behind must still read the old value.
                        if (!s[j] && e_des[k] != '0 && (e_s1[j] == e_des[k]
                            || (s2_used[j] && e_s2[j] == e_des[k])))
                            ok = 1'b0;
                    end
                end
                if (ok && !b_hit) begin
                    s[k] = 1'b1;
                    if (!a_hit) begin
                        a_hit = 1'b1;
                        a_idx = 2'(k);
                    end else begin
                        b_hit = 1'b1;
                        b_idx = 2'(k);
                    end
                end
            end
        end
        sel = s;
    end

    assign ins_in_1 = sel[0];
    assign ins_in_2 = sel[1];
    assign ins_in_3 = sel[2];
    assign ins_in_4 = sel[3];

    always_comb begin
        set_mask = '0;
        if (a_hit) set_mask[e_des[a_idx]] = 1'b1;
        if (b_hit) set_mask[e_des[b_idx]] = 1'b1;
        set_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy      <= '0;
            iss_a_vld    <= 1'b0;
            iss_a_des    <= '0;
            iss_a_s1     <= '0;
            iss_a_s2     <= '0;
            iss_a_op     <= '0;
            iss_a_ime    <= '0;
            iss_a_branch <= 1'b0;
            iss_b_vld    <= 1'b0;
            iss_b_des    <= '0;
            iss_b_s1     <= '0;
            iss_b_s2     <= '0;
            iss_b_op     <= '0;
            iss_b_ime    <= '0;
            iss_b_branch <= 1'b0;
        end else if (flush_en) begin
            sb_busy   <= '0;
            iss_a_vld <= 1'b0;
            iss_b_vld <= 1'b0;
        end else if (ex_stall) begin
            sb_busy <= sb_busy & ~wb_clr;
        end else begin
            // Set after clear: a same-cycle issue keeps its register busy.
            sb_busy   <= (sb_busy & ~wb_clr) | set_mask;
            iss_a_vld <= a_hit;
            iss_b_vld <= b_hit;
            if (a_hit) begin
                iss_a_des    <= e_des[a_idx];
                iss_a_s1     <= e_s1[a_idx];
                iss_a_s2     <= e_s2[a_idx];
                iss_a_op     <= e_op[a_idx];
                iss_a_ime    <= e_ime[a_idx];
                iss_a_branch <= e_br[a_idx];
            end
            if (b_hit) begin
                iss_b_des    <= e_des[b_idx];
                iss_b_s1     <= e_s1[b_idx];
                iss_b_s2     <= e_s2[b_idx];
                iss_b_op     <= e_op[b_idx];
                iss_b_ime    <= e_ime[b_idx];
                iss_b_branch <= e_br[b_idx];
            end
        end
    end

endmodule
